// File: rtl/jtdsp16_sdo_rx_pkg.sv
// Shared DSP16 serial-output constants: word geometry, receiver state encodings
// and the shift-register update used by the serial receiver.
package jtdsp16_sdo_rx_pkg;

  localparam int unsigned WordW = 16;
  localparam int unsigned PairW = 2 * WordW;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } rx_state_e;

  // LSB-first streams enter at bit 15 and shift right; MSB-first enter at bit 0.
  function automatic logic [WordW-1:0] shift_in(logic [WordW-1:0] sr, logic d, bit msb_first);
    return msb_first ? {sr[WordW-2:0], d} : {d, sr[WordW-1:1]};
  endfunction

endpackage

// File: rtl/jtdsp16_sdo_rx_if.sv
// Stereo-pair output bus of the serial receiver: FIFO head, valid/ready and occupancy.
interface jtdsp16_sdo_rx_if
  import jtdsp16_sdo_rx_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
);
  logic [WordW-1:0] left;
  logic [WordW-1:0] right;
  logic             out_valid;
  logic             out_ready;
  logic [FIFO_AW:0] level;

  modport master (output left, right, out_valid, level, input out_ready);
  modport slave  (input left, right, out_valid, level, output out_ready);
endinterface

// File: rtl/jtdsp16_sdo_fifo.sv
// Synchronous FIFO of stereo pairs; a push while full is dropped and flagged
// unless a pop frees the slot on the same clock.
module jtdsp16_sdo_fifo
  import jtdsp16_sdo_rx_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PairW-1:0] din,
  input  logic             pop,
  output logic [PairW-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic             ovf
);
  localparam int unsigned Depth = 2 ** AW;

  logic [PairW-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(Depth));
  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign level   = level_q;
  assign ovf     = ovf_q;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= push & full & ~do_pop;
    end
  end

endmodule

// File: rtl/jtdsp16_sdo_rx.sv
// DSP16 serial output receiver: oversamples ock, deserialises 16-bit words,
// pairs them as left/right and queues the pairs for the audio consumer.
module jtdsp16_sdo_rx
  import jtdsp16_sdo_rx_pkg::*;
#(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ock,
  input  logic sdo,
  input  logic old,
  input  logic ose,
  output logic frame_err,
  output logic ovf,
  jtdsp16_sdo_rx_if.master aud
);
  rx_state_e        state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [WordW-1:0] sreg_q, sreg_d, lhold_q, lhold_d, word;
  logic [PairW-1:0] pair_q, pair_d, head;
  logic             ock_l, rise;
  logic             ch_q, ch_d;
  logic             push_q, push_d;
  logic             ferr_q, ferr_d;
  logic             fifo_empty, fifo_full;

  assign rise      = ock & ~ock_l;
  assign word      = shift_in(sreg_q, sdo, MSB_FIRST);
  assign frame_err = ferr_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    lhold_d  = lhold_q;
    pair_d   = pair_q;
    ch_d     = ch_q;
    push_d   = 1'b0;
    ferr_d   = 1'b0;
    if (rise) begin
      unique case (state_q)
        StIdle: begin
          // The load edge only marks the word start; no data bit is taken.
          if (old) begin
            state_d  = StShift;
            bitcnt_d = '0;
          end
        end
        StShift: begin
          if (old) begin
            ferr_d   = 1'b1;
            bitcnt_d = '0;
          end else if (ose) begin
            ferr_d   = 1'b1;
            state_d  = StIdle;
            bitcnt_d = '0;
          end else begin
            sreg_d   = word;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd15) begin
              state_d  = StIdle;
              bitcnt_d = '0;
              if (!ch_q) begin
                lhold_d = word;
                ch_d    = 1'b1;
              end else begin
                pair_d = {lhold_q, word};
                push_d = 1'b1;
                ch_d   = 1'b0;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ock_l    <= 1'b0;
      state_q  <= StIdle;
      bitcnt_q <= '0;
      sreg_q   <= '0;
      lhold_q  <= '0;
      pair_q   <= '0;
      ch_q     <= 1'b0;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ock_l    <= ock;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
      lhold_q  <= lhold_d;
      pair_q   <= pair_d;
      ch_q     <= ch_d;
      push_q   <= push_d;
      ferr_q   <= ferr_d;
    end
  end

  jtdsp16_sdo_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (pair_q),
    .pop   (aud.out_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (aud.level),
    .ovf   (ovf)
  );

  assign aud.left      = head[PairW-1:WordW];
  assign aud.right     = head[WordW-1:0];
  assign aud.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_jtdsp16_sdo_rx.sv
// Scoreboard bench: an LSB-first and an MSB-first receiver fed the same words;
// expected pairs are queued at stimulus time and checked as the FIFO pops.
module tb_jtdsp16_sdo_rx;
  import jtdsp16_sdo_rx_pkg::*;

  logic clk = 1'b0, rst = 1'b1, ock = 1'b0, old = 1'b0, ose = 1'b0, ready = 1'b0;
  logic sdo0 = 1'b0, sdo1 = 1'b0;
  logic fe0, fe1, ovf0, ovf1;

  jtdsp16_sdo_rx_if #(.FIFO_AW(2)) aud0 ();
  jtdsp16_sdo_rx_if #(.FIFO_AW(2)) aud1 ();
  assign aud0.out_ready = ready;
  assign aud1.out_ready = ready;

  jtdsp16_sdo_rx #(.MSB_FIRST(1'b0), .FIFO_AW(2)) dut0 (
    .clk(clk), .rst(rst), .ock(ock), .sdo(sdo0), .old(old), .ose(ose),
    .frame_err(fe0), .ovf(ovf0), .aud(aud0)
  );
  jtdsp16_sdo_rx #(.MSB_FIRST(1'b1), .FIFO_AW(2)) dut1 (
    .clk(clk), .rst(rst), .ock(ock), .sdo(sdo1), .old(old), .ose(ose),
    .frame_err(fe1), .ovf(ovf1), .aud(aud1)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int fe0_n = 0, fe1_n = 0, ovf0_n = 0, ovf1_n = 0;
  logic [31:0] exp_q0[$], exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pulse counting and scoreboard pops, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (fe0) fe0_n++;
      if (fe1) fe1_n++;
      if (ovf0) ovf0_n++;
      if (ovf1) ovf1_n++;
      if (aud0.out_valid && ready) begin
        if (exp_q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb0_unexpected: got %h expected none", {aud0.left, aud0.right});
        end else check("sb0_pair", {aud0.left, aud0.right}, exp_q0.pop_front());
      end
      if (aud1.out_valid && ready) begin
        if (exp_q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb1_unexpected: got %h expected none", {aud1.left, aud1.right});
        end else check("sb1_pair", {aud1.left, aud1.right}, exp_q1.pop_front());
      end
    end
  end

  task automatic ock_rise(input logic d0, input logic d1, input logic o, input logic s);
    sdo0 = d0; sdo1 = d1; old = o; ose = s; ock = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic ock_fall();
    ock = 1'b0; old = 1'b0; ose = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic d0, input logic d1, input logic o, input logic s);
    ock_rise(d0, d1, o, s);
    @(posedge clk); #1;
    ock_fall();
  endtask

  // Load edge then n data bits; leave_open stops right after the last capture edge.
  task automatic send_bits(input logic [15:0] w, input int n, input bit leave_open);
    bit_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (leave_open && i == n - 1) ock_rise(w[i], w[15-i], 1'b0, 1'b0);
      else bit_cycle(w[i], w[15-i], 1'b0, 1'b0);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 16, 1'b0);
  endtask

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    exp_q0.push_back({l, r});
    exp_q1.push_back({l, r});
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((aud0.out_valid || aud1.out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got valid %b%b expected 00", name, aud0.out_valid, aud1.out_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_left", {aud0.left, aud1.left}, 32'h0);
    check("rst_right", {aud0.right, aud1.right}, 32'h0);
    check("rst_valid_lvl", {aud0.out_valid, aud1.out_valid, aud0.level, aud1.level}, 32'h0);
    check("rst_pulses", {fe0, fe1, ovf0, ovf1}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic pair with latency check: valid appears 2 clks after the final rise.
    ready = 1'b1;
    expect_pair(16'h1234, 16'hABCD);
    send_word(16'h1234);
    send_bits(16'hABCD, 16, 1'b1);
    check("lat_1clk", {aud0.out_valid, aud1.out_valid}, 32'h0);
    @(posedge clk); #1;
    check("lat_2clk", {aud0.out_valid, aud1.out_valid}, 32'h3);
    check("head0_direct", {aud0.left, aud0.right}, 32'h1234ABCD);
    @(posedge clk); #1;
    ock_fall();
    check("level_after_pop", {aud0.level, aud1.level}, 32'h0);

    expect_pair(16'hF00D, 16'h0042);
    send_word(16'hF00D);
    send_word(16'h0042);
    wait_empty("t2");
    check("no_frame_err", fe0_n + fe1_n, 32'd0);

    // Abort after 7 bits; the restarted word is still the left sample.
    expect_pair(16'h5555, 16'h0F0F);
    send_bits(16'hC3C3, 7, 1'b0);
    send_word(16'h5555);
    send_word(16'h0F0F);
    wait_empty("t3");
    check("abort_ferr0", fe0_n, 32'd1);
    check("abort_ferr1", fe1_n, 32'd1);

    // Overflow: 5 pairs into a 4-deep FIFO with the consumer stalled.
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
      send_word(16'h1000 + 16'(i));
      send_word(16'h2000 + 16'(i));
    end
    check("full_level", {aud0.level, aud1.level}, {26'h0, 3'd4, 3'd4});
    check("no_ovf_yet", ovf0_n + ovf1_n, 32'd0);
    send_word(16'h1005);
    send_word(16'h2005);
    check("ovf_once", {ovf0_n[15:0], ovf1_n[15:0]}, {16'd1, 16'd1});
    check("ovf_level", {aud0.level, aud1.level}, {26'h0, 3'd4, 3'd4});
    check("ovf_head", {aud1.left, aud1.right}, 32'h10012001);
    ready = 1'b1;
    wait_empty("t4");

    // Push on full coinciding with a pop: both take effect, no overflow.
    ready = 1'b0;
    for (int i = 6; i <= 10; i++) expect_pair(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    for (int i = 6; i <= 9; i++) begin
      send_word(16'h3000 + 16'(i));
      send_word(16'h4000 + 16'(i));
    end
    send_word(16'h300A);
    send_bits(16'h400A, 16, 1'b1);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check("pushpop_level", {aud0.level, aud1.level}, {26'h0, 3'd4, 3'd4});
    @(posedge clk); #1;
    ock_fall();
    check("pushpop_no_ovf", {ovf0_n[15:0], ovf1_n[15:0]}, {16'd1, 16'd1});
    ready = 1'b1;
    wait_empty("t5");

    // Reset with a stored pair, a held left word and a partial word in flight.
    ready = 1'b0;
    send_word(16'hDEAD);
    send_word(16'hBEEF);
    send_word(16'h7777);
    send_bits(16'h01FF, 9, 1'b0);
    check("pre_rst_level", aud0.level, 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_out", {aud0.left, aud1.right}, 32'h0);
    check("mid_rst_valid", {aud0.out_valid, aud1.out_valid, aud0.level, aud1.level}, 32'h0);
    check("mid_rst_pulses", {fe0, fe1, ovf0, ovf1}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    ready = 1'b1;
    expect_pair(16'h0001, 16'h8000);
    send_word(16'h0001);
    send_word(16'h8000);
    wait_empty("t6");
    check("final_ferr", {fe0_n[15:0], fe1_n[15:0]}, {16'd1, 16'd1});

    repeat (4) @(posedge clk);
    check("sb0_drained", exp_q0.size(), 32'd0);
    check("sb1_drained", exp_q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
